aes_dec_controller: RTL



---
 rtl/aes_dec_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/aes_dec_controller.sv
// Control FSM for the iterative AES-128 decryption datapath: sequences register enables,
// round-select flags and the round-counter decrement. Optional AES_DEC_ABORT_EN adds an abort input.
module aes_dec_controller (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic count_gt_0,
  input  logic count_eq_9,
`ifdef AES_DEC_ABORT_EN
  input  logic abort,
`endif
  output logic init,
  output logic isRound10,
  output logic isRound9,
  output logic dec_count,
  output logic en_round_out,
  output logic en_reg_inv_row_out,
  output logic en_reg_inv_sub_out,
  output logic en_reg_inv_col_out,
  output logic en_Dout,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    R10  = 3'd1,
    ROW  = 3'd2,
    SUB  = 3'd3,
    ADD  = 3'd4,
    COL  = 3'd5,
    OUT  = 3'd6,
    DONE = 3'd7
  } state_e;

  localparam int unsigned B_R10  = 8;
  localparam int unsigned B_DEC  = 7;
  localparam int unsigned B_RND  = 6;
  localparam int unsigned B_ROW  = 5;
  localparam int unsigned B_SUB  = 4;
  localparam int unsigned B_COL  = 3;
  localparam int unsigned B_DOUT = 2;
  localparam int unsigned B_BUSY = 1;
  localparam int unsigned B_DONE = 0;

  state_e     state_q;
  state_e     state_d;
  state_e     nxt_s;
  logic [8:0] moore_q;
  logic [8:0] moore_d;
  logic       abort_s;
  logic       abortable_s;

`ifdef AES_DEC_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // State-only outputs, registered one cycle ahead so they line up with state_q
  function automatic logic [8:0] decode_moore(input state_e s);
    logic [8:0] v;
    v = 9'b0;
    case (s)
      IDLE: v = 9'b0;
      R10: begin
        v[B_R10]  = 1'b1;
        v[B_DEC]  = 1'b1;
        v[B_RND]  = 1'b1;
        v[B_BUSY] = 1'b1;
      end
      ROW: begin
        v[B_ROW]  = 1'b1;
        v[B_BUSY] = 1'b1;
      end
      SUB: begin
        v[B_SUB]  = 1'b1;
        v[B_BUSY] = 1'b1;
      end
      ADD: begin
        v[B_DEC]  = 1'b1;
        v[B_RND]  = 1'b1;
        v[B_BUSY] = 1'b1;
      end
      COL: begin
        v[B_COL]  = 1'b1;
        v[B_BUSY] = 1'b1;
      end
      OUT: begin
        v[B_DOUT] = 1'b1;
        v[B_BUSY] = 1'b1;
      end
      DONE: begin
        v[B_BUSY] = 1'b1;
        v[B_DONE] = 1'b1;
      end
      default: v = 9'b0;
    endcase
    return v;
  endfunction

  // Next-state logic, with abort override for in-flight rounds
  always_comb begin
    nxt_s = state_q;
    case (state_q)
      IDLE: begin
        if (start) nxt_s = R10;
        else       nxt_s = IDLE;
      end
      R10: nxt_s = ROW;
      ROW: nxt_s = SUB;
      SUB: begin
        if (count_gt_0) nxt_s = ADD;
        else            nxt_s = OUT;
      end
      ADD:     nxt_s = COL;
      COL:     nxt_s = ROW;
      OUT:     nxt_s = DONE;
      DONE:    nxt_s = IDLE;
      default: nxt_s = IDLE;
    endcase
    abortable_s = (state_q != IDLE) && (state_q != DONE);
    state_d     = (abort_s && abortable_s) ? IDLE : nxt_s;
    moore_d     = decode_moore(state_d);
  end

  // State and state-decoded output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      moore_q <= 9'b0;
    end else begin
      state_q <= state_d;
      moore_q <= moore_d;
    end
  end

  // init and isRound9 depend on live inputs; init is masked so reset silences it at once
  assign init               = start & (state_q == IDLE) & ~reset;
  assign isRound9           = (state_q == ROW) & count_eq_9;
  assign isRound10          = moore_q[B_R10];
  assign dec_count          = moore_q[B_DEC];
  assign en_round_out       = moore_q[B_RND];
  assign en_reg_inv_row_out = moore_q[B_ROW];
  assign en_reg_inv_sub_out = moore_q[B_SUB];
  assign en_reg_inv_col_out = moore_q[B_COL];
  assign en_Dout            = moore_q[B_DOUT] & ~abort_s;
  assign busy               = moore_q[B_BUSY];
  assign done               = moore_q[B_DONE];

endmodule
